// File: rtl/dmul_rot_lanes.sv
// dmul_rot_lanes: multi-lane deterministic stochastic multiplier.
// Two shared W-bit counters rotate against each other so that every
// (cntA, cntB) pair appears exactly once in N^2 cycles. Each lane compares
// its captured operands against the counters and counts coincidences,
// giving an exact product count at the end of the run.
//
// Optional feature: define DMUL_ROT_BIPOLAR_EN to honour `mode` and build
// the XNOR (bipolar) path. Without it every lane is unipolar (AND) and the
// mode input is not used.
//
// Handshake: `start` is accepted on a rising edge whenever the block is
// not in RUN (i.e. in IDLE or in the one-cycle DONE state). `busy` is high
// for the whole run, `done` pulses for one cycle when `oC` is final, and
// `oC` then holds until the next accepted start clears it.
module dmul_rot_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mode,
    input  logic [LANES*WIDTH-1:0]         iA,
    input  logic [LANES*WIDTH-1:0]         iB,
    output logic                           busy,
    output logic                           done,
    output logic [LANES*(2*WIDTH+1)-1:0]   oC
);

    localparam int CW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT              state;
    logic [WIDTH-1:0]   cntA;
    logic [WIDTH-1:0]   cntB;
    logic [2*WIDTH-1:0] cycCnt;

    logic [WIDTH-1:0]   aBuf [LANES];
    logic [WIDTH-1:0]   bBuf [LANES];
    logic [CW-1:0]      acc  [LANES];
    logic               hit  [LANES];

    logic               accept;

`ifdef DMUL_ROT_BIPOLAR_EN
    logic               modeBuf;
`else
    logic               unusedMode;
    assign unusedMode = mode;
`endif

    // A new run may begin from IDLE or directly from the DONE cycle.
    assign accept = start && (state != RUN);

    // Control FSM, rotation counters and registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cntA   <= '0;
            cntB   <= '0;
            cycCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cntA   <= '0;
                        cntB   <= '0;
                        cycCnt <= '0;
                    end
                end
                RUN: begin
                    cntA   <= cntA + 1'b1;
                    // B holds once per A period so its phase slips by one.
                    if (cntA != {WIDTH{1'b1}}) begin
                        cntB <= cntB + 1'b1;
                    end
                    cycCnt <= cycCnt + 1'b1;
                    // Last of the N^2 accumulation cycles.
                    if (cycCnt == {(2*WIDTH){1'b1}}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cntA   <= '0;
                        cntB   <= '0;
                        cycCnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane stream bits and the coincidence function for this cycle.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            hit[i] = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
`ifdef DMUL_ROT_BIPOLAR_EN
            if (modeBuf) begin
                hit[i] = ~((aBuf[i] > cntA) ^ (bBuf[i] > cntB));
            end else begin
                hit[i] = (aBuf[i] > cntA) & (bBuf[i] > cntB);
            end
`else
            hit[i] = (aBuf[i] > cntA) & (bBuf[i] > cntB);
`endif
        end
    end

`ifdef DMUL_ROT_BIPOLAR_EN
    // Mode is latched with the operands so mid-run changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modeBuf <= 1'b0;
        end else if (accept) begin
            modeBuf <= mode;
        end
    end
`endif

    // Operand capture on accepted start and accumulation during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                aBuf[i] <= '0;
                bBuf[i] <= '0;
                acc[i]  <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                aBuf[i] <= iA[i*WIDTH +: WIDTH];
                bBuf[i] <= iB[i*WIDTH +: WIDTH];
                acc[i]  <= '0;
            end
        end else if (state == RUN) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= acc[i] + {{(CW-1){1'b0}}, hit[i]};
            end
        end
    end

    // Pack the lane accumulators onto the result bus.
    always_comb begin
        oC = '0;
        for (int i = 0; i < LANES; i++) begin
            oC[i*CW +: CW] = acc[i];
        end
    end

endmodule

// File: tb/tb_dmul_rot_lanes.sv
// Bench for dmul_rot_lanes: a small instance (WIDTH=2, LANES=2) for the
// directed functional and handshake cases, and a full-size instance
// (WIDTH=8, LANES=4) run in parallel for the long product and abort case.
// Expected results are pushed into per-instance queues when a run is
// started; monitors pop and compare whenever the instance pulses done.
module tb_dmul_rot_lanes;

    localparam int SW  = 2;
    localparam int SL  = 2;
    localparam int SCW = 2 * SW + 1;
    localparam int BW  = 8;
    localparam int BL  = 4;
    localparam int BCW = 2 * BW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstS   = 1'b1;
    logic                 startS = 1'b0;
    logic                 modeS  = 1'b0;
    logic [SL*SW-1:0]     iAS    = '0;
    logic [SL*SW-1:0]     iBS    = '0;
    logic                 busyS;
    logic                 doneS;
    logic [SL*SCW-1:0]    oCS;

    logic                 rstB   = 1'b1;
    logic                 startB = 1'b0;
    logic                 modeB  = 1'b0;
    logic [BL*BW-1:0]     iAB    = '0;
    logic [BL*BW-1:0]     iBB    = '0;
    logic                 busyB;
    logic                 doneB;
    logic [BL*BCW-1:0]    oCB;

    dmul_rot_lanes #(.WIDTH(SW), .LANES(SL)) dutS (
        .clk   (clk),
        .rst   (rstS),
        .start (startS),
        .mode  (modeS),
        .iA    (iAS),
        .iB    (iBS),
        .busy  (busyS),
        .done  (doneS),
        .oC    (oCS)
    );

    dmul_rot_lanes #(.WIDTH(BW), .LANES(BL)) dutB (
        .clk   (clk),
        .rst   (rstB),
        .start (startB),
        .mode  (modeB),
        .iA    (iAB),
        .iB    (iBB),
        .busy  (busyB),
        .done  (doneB),
        .oC    (oCB)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [SL*SCW-1:0] expS_q[$];
    logic [BL*BCW-1:0] expB_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor for the small instance: every done pulse must match a queued result.
    always @(negedge clk) begin
        if (doneS === 1'b1) begin
            if (expS_q.size() == 0) begin
                checks++;
                $display("FAIL small_done_unexpected: got done pulse, required no pulse (queue empty)");
            end else begin
                chk("small_oC", oCS, expS_q.pop_front());
            end
        end
    end

    // Monitor for the full-size instance.
    always @(negedge clk) begin
        if (doneB === 1'b1) begin
            if (expB_q.size() == 0) begin
                checks++;
                $display("FAIL big_done_unexpected: got done pulse, required no pulse (queue empty)");
            end else begin
                chk("big_oC", oCB, expB_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Count rising edges until done is seen (sampled on the falling edge).
    task automatic waitDoneS(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (doneS !== 1'b1 && n < budget);
    endtask

    task automatic waitDoneB(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (doneB !== 1'b1 && n < budget);
    endtask

    task automatic smallSeq();
        int n;
        // Reset with start held high: no run may begin.
        rstS   = 1'b1;
        startS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstS   = 1'b0;
        startS = 1'b0;
        @(negedge clk);
        chk("small_rst_busy", busyS, 0);
        chk("small_rst_done", doneS, 0);
        chk("small_rst_oC", oCS, 0);
        repeat (3) @(negedge clk);
        chk("small_no_run_after_rst_start", busyS, 0);

        // Unipolar: lane0 3*2=6, lane1 0*3=0.
        @(posedge clk);
        #1;
        iAS = {2'd0, 2'd3};
        iBS = {2'd3, 2'd2};
        modeS = 1'b0;
        startS = 1'b1;
        expS_q.push_back({5'd0, 5'd6});
        @(posedge clk);
        #1;
        startS = 1'b0;
        @(negedge clk);
        chk("small_uni_busy", busyS, 1);
        waitDoneS(40, n);
        chk("small_uni_latency", n, 16);
        chk("small_uni_busy_at_done", busyS, 0);
        @(negedge clk);
        chk("small_done_one_cycle", doneS, 0);
        chk("small_oC_hold", oCS, {5'd0, 5'd6});

        // Mode 1: lane0 A=3 B=1, lane1 A=0 B=0.
        @(posedge clk);
        #1;
        iAS = {2'd0, 2'd3};
        iBS = {2'd0, 2'd1};
        modeS = 1'b1;
        startS = 1'b1;
`ifdef DMUL_ROT_BIPOLAR_EN
        expS_q.push_back({5'd16, 5'd6});
`else
        expS_q.push_back({5'd0, 5'd3});
`endif
        @(posedge clk);
        #1;
        startS = 1'b0;
        waitDoneS(40, n);
        chk("small_mode1_latency", n, 16);

        // Start held through RUN, operands changed mid-run, restart in DONE.
        @(posedge clk);
        #1;
        iAS = {2'd1, 2'd2};
        iBS = {2'd3, 2'd2};
        modeS = 1'b0;
        startS = 1'b1;
        expS_q.push_back({5'd3, 5'd4});
`ifdef DMUL_ROT_BIPOLAR_EN
        expS_q.push_back({5'd10, 5'd6});
`else
        expS_q.push_back({5'd9, 5'd3});
`endif
        @(posedge clk);
        #1;
        iAS = {2'd3, 2'd1};
        iBS = {2'd3, 2'd3};
        modeS = 1'b1;
        waitDoneS(40, n);
        chk("small_hold_start_latency", n, 16);
        @(posedge clk);
        #1;
        startS = 1'b0;
        @(negedge clk);
        chk("small_b2b_busy", busyS, 1);
        chk("small_b2b_done_low", doneS, 0);
        chk("small_b2b_oC_cleared", oCS, 0);
        waitDoneS(40, n);
        chk("small_b2b_latency", n, 16);
        repeat (2) @(negedge clk);
    endtask

    task automatic bigSeq();
        int n;
        int seen;
        rstB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstB = 1'b0;
        @(negedge clk);
        chk("big_rst_busy", busyB, 0);
        chk("big_rst_oC", oCB, 0);

        // Full width: 255*255 = 65025 on every lane.
        @(posedge clk);
        #1;
        iAB = {4{8'd255}};
        iBB = {4{8'd255}};
        modeB = 1'b0;
        startB = 1'b1;
        expB_q.push_back({4{17'd65025}});
        @(posedge clk);
        #1;
        startB = 1'b0;
        waitDoneB(70000, n);
        chk("big_latency", n, 65536);

        // Second run, aborted by reset around cycle 1000.
        @(posedge clk);
        #1;
        startB = 1'b1;
        @(posedge clk);
        #1;
        startB = 1'b0;
        repeat (999) @(posedge clk);
        @(negedge clk);
        chk("big_busy_midrun", busyB, 1);
        @(posedge clk);
        #1;
        rstB = 1'b1;
        @(negedge clk);
        chk("big_abort_busy", busyB, 0);
        chk("big_abort_done", doneB, 0);
        chk("big_abort_oC", oCB, 0);
        @(posedge clk);
        #1;
        rstB = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (doneB === 1'b1) seen++;
        end
        chk("big_no_done_after_abort", seen, 0);
        chk("big_oC_after_abort", oCB, 0);
    endtask

    // ---------------- main / final report ----------------
    initial begin
        fork
            smallSeq();
            bigSeq();
        join
        @(negedge clk);
        chk("small_queue_drained", expS_q.size(), 0);
        chk("big_queue_drained", expB_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

endmodule
